// File: rtl/quad_pkg.sv
// Shared encodings for the quadrature step decoder: AB level codes,
// step directions and the transition classes produced by the decoder.
package quad_pkg;

    localparam logic [1:0] AB_00 = 2'b00;
    localparam logic [1:0] AB_10 = 2'b10;
    localparam logic [1:0] AB_11 = 2'b11;
    localparam logic [1:0] AB_01 = 2'b01;

    localparam logic DIR_RIGHT = 1'b0;
    localparam logic DIR_LEFT  = 1'b1;

    typedef enum logic [1:0] {
        T_NONE,
        T_CW,
        T_CCW,
        T_ILLEGAL
    } trans_t;

    // Successor of an AB code when turning right (00->10->11->01->00).
    function automatic logic [1:0] cw_next(input logic [1:0] ab);
        logic [1:0] nxt;
        case (ab)
            AB_00:   nxt = AB_10;
            AB_10:   nxt = AB_11;
            AB_11:   nxt = AB_01;
            default: nxt = AB_00;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/quad_transition_decode.sv
// Classifies one AB sample against the previous one as no change,
// a clockwise step, a counter-clockwise step or an illegal double-bit jump.
module quad_transition_decode
    import quad_pkg::*;
(
    input  logic [1:0] prev_ab,
    input  logic [1:0] ab,
    output trans_t     trans
);

    always_comb begin
        trans = T_NONE;
        if (ab == prev_ab) begin
            trans = T_NONE;
        end else if (ab == cw_next(prev_ab)) begin
            trans = T_CW;
        end else if (prev_ab == cw_next(ab)) begin
            trans = T_CCW;
        end else begin
            trans = T_ILLEGAL;
        end
    end

endmodule

// File: rtl/quadrature_step_decoder.sv
// Turns debounced encoder A/B levels into one-cycle detent step events.
// Optional wrap-around position counter is built when QUAD_POSITION_EN is defined.
module quadrature_step_decoder
    import quad_pkg::*;
#(
    parameter int STEPS_PER_DETENT = 4,
    parameter int POS_WIDTH        = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 quad_a,
    input  logic                 quad_b,
    output logic                 step_event,
    output logic                 step_left,
    output logic                 quad_error,
    output logic [POS_WIDTH-1:0] position
);

    localparam logic signed [3:0] STEP_POS = 4'(STEPS_PER_DETENT);
    localparam logic signed [3:0] STEP_NEG = -STEP_POS;

    logic [1:0]        ab;
    logic [1:0]        prev_ab;
    logic              primed;
    logic signed [3:0] sub_cnt;
    trans_t            trans;

    logic signed [3:0] sub_cnt_nxt;
    logic signed [3:0] sub_upd;
    logic              step_event_nxt;
    logic              step_left_nxt;
    logic              quad_error_nxt;

    assign ab = {quad_a, quad_b};

    quad_transition_decode u_decode (
        .prev_ab (prev_ab),
        .ab      (ab),
        .trans   (trans)
    );

    // Until primed, the previous sample is meaningless, so nothing is decoded.
    always_comb begin
        sub_cnt_nxt    = sub_cnt;
        sub_upd        = sub_cnt;
        step_event_nxt = 1'b0;
        step_left_nxt  = step_left;
        quad_error_nxt = 1'b0;
        if (primed) begin
            case (trans)
                T_CW: begin
                    sub_upd = sub_cnt + 4'sd1;
                    if (sub_upd == STEP_POS) begin
                        step_event_nxt = 1'b1;
                        step_left_nxt  = DIR_RIGHT;
                        sub_cnt_nxt    = '0;
                    end else begin
                        sub_cnt_nxt = sub_upd;
                    end
                end
                T_CCW: begin
                    sub_upd = sub_cnt - 4'sd1;
                    if (sub_upd == STEP_NEG) begin
                        step_event_nxt = 1'b1;
                        step_left_nxt  = DIR_LEFT;
                        sub_cnt_nxt    = '0;
                    end else begin
                        sub_cnt_nxt = sub_upd;
                    end
                end
                T_ILLEGAL: begin
                    quad_error_nxt = 1'b1;
                    sub_cnt_nxt    = '0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_ab    <= AB_00;
            primed     <= 1'b0;
            sub_cnt    <= '0;
            step_event <= 1'b0;
            step_left  <= 1'b0;
            quad_error <= 1'b0;
        end else begin
            prev_ab    <= ab;
            primed     <= 1'b1;
            sub_cnt    <= sub_cnt_nxt;
            step_event <= step_event_nxt;
            step_left  <= step_left_nxt;
            quad_error <= quad_error_nxt;
        end
    end

`ifdef QUAD_POSITION_EN
    logic [POS_WIDTH-1:0] pos_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_cnt <= '0;
        end else if (step_event_nxt) begin
            if (step_left_nxt == DIR_LEFT) begin
                pos_cnt <= pos_cnt - POS_WIDTH'(1);
            end else begin
                pos_cnt <= pos_cnt + POS_WIDTH'(1);
            end
        end
    end

    assign position = pos_cnt;
`else
    assign position = '0;
`endif

endmodule

// File: tb/tb_quadrature_step_decoder.sv
// Directed, table-driven bench for quadrature_step_decoder: a 4-step instance
// for the main sequences and a 1-step instance for per-transition events.
module tb_quadrature_step_decoder;

    logic       clk;
    logic       rst_n;
    logic [1:0] ab4;
    logic [1:0] ab1;

    logic       ev4, left4, err4;
    logic [7:0] pos4;
    logic       ev1, left1, err1;
    logic [7:0] pos1;

    int tests_run;
    int tests_failed;

    typedef struct {
        logic [1:0] ab;
        int         hold;
        logic       ev;
        logic       left;
        logic       err;
        logic [7:0] pos;
        string      tag;
    } vec_t;

    vec_t vecs[$];

    quadrature_step_decoder #(.STEPS_PER_DETENT(4), .POS_WIDTH(8)) u_dut4 (
        .clk        (clk),
        .rst_n      (rst_n),
        .quad_a     (ab4[1]),
        .quad_b     (ab4[0]),
        .step_event (ev4),
        .step_left  (left4),
        .quad_error (err4),
        .position   (pos4)
    );

    quadrature_step_decoder #(.STEPS_PER_DETENT(1), .POS_WIDTH(8)) u_dut1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .quad_a     (ab1[1]),
        .quad_b     (ab1[0]),
        .step_event (ev1),
        .step_left  (left1),
        .quad_error (err1),
        .position   (pos1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    function automatic logic [7:0] posExpect(input logic [7:0] pos);
`ifdef QUAD_POSITION_EN
        return pos;
`else
        return (pos & 8'h00);
`endif
    endfunction

    // Drive AB on one instance, then check every cycle of the hold window;
    // pulses are expected only right after the first sampling edge.
    task automatic applyStimulus(input bit sel1, input logic [1:0] ab, input int hold,
                                 input logic ev, input logic left, input logic err,
                                 input logic [7:0] pos, input string tag);
        logic       a_ev, a_left, a_err;
        logic [7:0] a_pos;
        @(negedge clk);
        if (sel1) ab1 = ab; else ab4 = ab;
        for (int c = 0; c < hold; c++) begin
            @(posedge clk);
            #1;
            a_ev   = sel1 ? ev1   : ev4;
            a_left = sel1 ? left1 : left4;
            a_err  = sel1 ? err1  : err4;
            a_pos  = sel1 ? pos1  : pos4;
            checkOutput({tag, "_event"}, 8'(a_ev), (c == 0) ? 8'(ev) : 8'd0);
            checkOutput({tag, "_error"}, 8'(a_err), (c == 0) ? 8'(err) : 8'd0);
            if (c == 0 && ev) checkOutput({tag, "_left"}, 8'(a_left), 8'(left));
            checkOutput({tag, "_pos"}, a_pos, posExpect(pos));
        end
    endtask

    task automatic addVec(input logic [1:0] ab, input int hold, input logic ev,
                          input logic left, input logic err, input logic [7:0] pos, input string tag);
        vec_t v;
        v.ab = ab; v.hold = hold; v.ev = ev; v.left = left; v.err = err; v.pos = pos; v.tag = tag;
        vecs.push_back(v);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n = 1'b0;
        ab4   = 2'b00;
        ab1   = 2'b00;

        // prime, then test 1: one full CW detent
        addVec(2'b00, 3, 0, 0, 0, 8'd0,   "prime");
        addVec(2'b10, 5, 0, 0, 0, 8'd0,   "t1_10");
        addVec(2'b11, 5, 0, 0, 0, 8'd0,   "t1_11");
        addVec(2'b01, 5, 0, 0, 0, 8'd0,   "t1_01");
        addVec(2'b00, 5, 1, 0, 0, 8'd1,   "t1_done");
        // test 2: two CCW detents, position wraps below zero
        addVec(2'b01, 2, 0, 0, 0, 8'd1,   "t2a_01");
        addVec(2'b11, 2, 0, 0, 0, 8'd1,   "t2a_11");
        addVec(2'b10, 2, 0, 0, 0, 8'd1,   "t2a_10");
        addVec(2'b00, 2, 1, 1, 0, 8'd0,   "t2a_done");
        addVec(2'b01, 2, 0, 0, 0, 8'd0,   "t2b_01");
        addVec(2'b11, 2, 0, 0, 0, 8'd0,   "t2b_11");
        addVec(2'b10, 2, 0, 0, 0, 8'd0,   "t2b_10");
        addVec(2'b00, 2, 1, 1, 0, 8'd255, "t2b_wrap");
        // test 3: reversal mid-detent, then a full CW detent from zero
        addVec(2'b10, 2, 0, 0, 0, 8'd255, "t3_10");
        addVec(2'b11, 2, 0, 0, 0, 8'd255, "t3_11");
        addVec(2'b10, 2, 0, 0, 0, 8'd255, "t3_back10");
        addVec(2'b00, 2, 0, 0, 0, 8'd255, "t3_back00");
        addVec(2'b10, 2, 0, 0, 0, 8'd255, "t3_cw10");
        addVec(2'b11, 2, 0, 0, 0, 8'd255, "t3_cw11");
        addVec(2'b01, 2, 0, 0, 0, 8'd255, "t3_cw01");
        addVec(2'b00, 2, 1, 0, 0, 8'd0,   "t3_done");
        // test 4: illegal jump clears a partial count
        addVec(2'b10, 2, 0, 0, 0, 8'd0,   "t4_10");
        addVec(2'b01, 3, 0, 0, 1, 8'd0,   "t4_jump");
        addVec(2'b00, 2, 0, 0, 0, 8'd0,   "t4_00");
        addVec(2'b10, 2, 0, 0, 0, 8'd0,   "t4_10b");
        addVec(2'b11, 2, 0, 0, 0, 8'd0,   "t4_11");
        addVec(2'b01, 2, 1, 0, 0, 8'd1,   "t4_done");

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_event", 8'(ev4), 8'd0);
        checkOutput("reset_left",  8'(left4), 8'd0);
        checkOutput("reset_error", 8'(err4), 8'd0);
        checkOutput("reset_pos",   pos4, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(1'b0, vecs[i].ab, vecs[i].hold, vecs[i].ev, vecs[i].left,
                          vecs[i].err, vecs[i].pos, vecs[i].tag);
        end

        // test 5: reset after three CW transitions, release with AB=01
        applyStimulus(1'b0, 2'b00, 1, 0, 0, 0, 8'd1, "t5_00");
        applyStimulus(1'b0, 2'b10, 1, 0, 0, 0, 8'd1, "t5_10");
        applyStimulus(1'b0, 2'b11, 1, 0, 0, 0, 8'd1, "t5_11");
        @(negedge clk);
        rst_n = 1'b0;
        ab4   = 2'b01;
        #1;
        checkOutput("t5_rst_pos",   pos4, 8'd0);
        checkOutput("t5_rst_event", 8'(ev4), 8'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("t5_prime_event", 8'(ev4), 8'd0);
        checkOutput("t5_prime_error", 8'(err4), 8'd0);
        checkOutput("t5_prime_pos",   pos4, 8'd0);
        applyStimulus(1'b0, 2'b00, 2, 0, 0, 0, 8'd0, "t5_cw00");
        applyStimulus(1'b0, 2'b10, 2, 0, 0, 0, 8'd0, "t5_cw10");
        applyStimulus(1'b0, 2'b11, 2, 0, 0, 0, 8'd0, "t5_cw11");
        applyStimulus(1'b0, 2'b01, 2, 1, 0, 0, 8'd1, "t5_done");

        // test 6: one transition per detent on the second instance
        applyStimulus(1'b1, 2'b10, 2, 1, 0, 0, 8'd1, "t6_10");
        applyStimulus(1'b1, 2'b11, 2, 1, 0, 0, 8'd2, "t6_11");
        applyStimulus(1'b1, 2'b01, 2, 1, 0, 0, 8'd3, "t6_01");
        applyStimulus(1'b1, 2'b00, 2, 1, 0, 0, 8'd4, "t6_00");
        applyStimulus(1'b1, 2'b01, 2, 1, 1, 0, 8'd3, "t6_ccw01");
        applyStimulus(1'b1, 2'b10, 2, 0, 0, 1, 8'd3, "t6_jump");
        applyStimulus(1'b1, 2'b00, 2, 1, 1, 0, 8'd2, "t6_ccw00");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
